// File: rtl/toggle_rx_pkg.sv
// Shared types and defaults for the toggle-encoded event receiver.
// Holds the FSM state encoding and the arm-counter sizing helper.
package toggle_rx_pkg;

  typedef enum logic [1:0] {
    ARMING = 2'd0,
    IDLE   = 2'd1,
    PEND   = 2'd2
  } rx_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  // The arm counter has to be able to hold the value SYNC_STAGES.
  function automatic int arm_cnt_w(input int sync_stages);
    return $clog2(sync_stages + 1);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop level synchronizer for a single asynchronous bit.
// Every stage clears to 0 on reset.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receive side of a toggle-encoded event link: one event per level change of tog_in,
// presented as a pulse, a valid/ready event, a wrapping count and a sticky overrun flag.
module toggle_event_rx
  import toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             evt_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int ARM_W = arm_cnt_w(SYNC_STAGES);

  logic             tog_sync;
  logic             evt_edge;

  rx_state_e        state_q,     state_d;
  logic [ARM_W-1:0] arm_cnt_q,   arm_cnt_d;
  logic             tog_prev_q,  tog_prev_d;
  logic             pulse_q,     pulse_d;
  logic             valid_q,     valid_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             overrun_q,   overrun_d;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (tog_in),
    .q   (tog_sync)
  );

  // The chain only fills with the real level after release, so arming waits until
  // tog_prev has caught up with it; otherwise tog_in=1 at release looks like an event.
  assign evt_edge = (state_q != ARMING) && (tog_sync ^ tog_prev_q);

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    tog_prev_d = tog_sync;
    pulse_d    = evt_edge;
    valid_d    = valid_q;
    count_d    = count_q;
    overrun_d  = overrun_q;

    if (evt_edge) begin
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      ARMING: begin
        if (arm_cnt_q == ARM_W'(SYNC_STAGES)) begin
          state_d = IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      IDLE: begin
        if (evt_edge) begin
          state_d = PEND;
          valid_d = 1'b1;
        end
      end
      PEND: begin
        // A new edge while pending either replaces an accepted event or merges into it.
        if (evt_ready && !evt_edge) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ARMING;
        valid_d = 1'b0;
      end
    endcase

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if ((state_q == PEND) && evt_edge && !evt_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARMING;
      arm_cnt_q  <= '0;
      tog_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      tog_prev_q <= tog_prev_d;
      pulse_q    <= pulse_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  assign evt_pulse = pulse_q;
  assign evt_valid = valid_q;
  assign evt_count = count_q;
  assign overrun   = overrun_q;

endmodule
